vga_sync_decoder: RTL and testbench

//  Receive-side counterpart of hvsync_generator: samples a VGA stream (hsync, vsync, 3-bit pixel) in the clk50 domain.

---
 rtl/vga_sync_if.sv | 25 ++
 rtl/vga_sync_decoder.sv | 182 ++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_if.sv
// VGA receive bundle: raw sync/pixel inputs and the recovered timing/coordinate outputs.
// The source side (pattern generator or bench) is the master; the decoder is the slave.
interface vga_sync_if;
    logic        hsync_in;
    logic        vsync_in;
    logic [2:0]  pix_in;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  pix_out;
    logic        pix_valid;
    logic        locked;
    logic        frame_start;
    logic        sync_err;
    logic [10:0] h_total;
    logic [9:0]  v_total;

    modport master (
        output hsync_in, vsync_in, pix_in,
        input  x, y, pix_out, pix_valid, locked, frame_start, sync_err, h_total, v_total
    );
    modport slave (
        input  hsync_in, vsync_in, pix_in,
        output x, y, pix_out, pix_valid, locked, frame_start, sync_err, h_total, v_total
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Samples a VGA stream in the clk50 domain, measures line/frame timing, recovers x/y for each
// pixel slot and declares lock once two consecutive frames match.
module vga_sync_decoder #(
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int H_BP            = 48,
    parameter int H_ACT           = 640,
    parameter int V_BP            = 33,
    parameter int V_ACT           = 480
) (
    input  logic      clk50,
    input  logic      rst,
    vga_sync_if.slave bus
);
    typedef enum logic [1:0] {SEARCH, FIRST, VERIFY, LOCKED} state_e;

    localparam logic [10:0] H_LO = 11'(H_BP);
    localparam logic [10:0] H_HI = 11'(H_BP + H_ACT);
    localparam logic [9:0]  V_LO = 10'(V_BP);
    localparam logic [9:0]  V_HI = 10'(V_BP + V_ACT);

    logic        hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d, hs_p_q, hs_p_d;
    logic        vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d, vs_p_q, vs_p_d;
    logic [2:0]  pix_s1_q, pix_s1_d, pix_s2_q, pix_s2_d;
    logic [10:0] hcnt_q, hcnt_d, hpos_q, hpos_d, hper_q, hper_d, href_q, href_d;
    logic [9:0]  lcnt_q, lcnt_d, lpos_q, lpos_d, vper_q, vper_d, vref_q, vref_d;
    state_e      state_q, state_d;
    logic        hbad_q, hbad_d, hfirst_q, hfirst_d;
    logic        locked_q, locked_d, sync_err_q, sync_err_d, frame_start_q, frame_start_d;
    logic [10:0] h_total_q, h_total_d;
    logic [9:0]  v_total_q, v_total_d, x_q, x_d, y_q, y_d;
    logic [2:0]  pix_out_q, pix_out_d;
    logic        pix_valid_q, pix_valid_d;
    logic        h_edge, h_fall, v_edge, v_fall, vis, h_mis;

    // Syncs are normalised before the first flop so 1 always means asserted.
    always_comb begin
        hs_s1_d  = bus.hsync_in ^ SYNC_ACTIVE_LOW;
        vs_s1_d  = bus.vsync_in ^ SYNC_ACTIVE_LOW;
        hs_s2_d  = hs_s1_q;
        vs_s2_d  = vs_s1_q;
        hs_p_d   = hs_s2_q;
        vs_p_d   = vs_s2_q;
        pix_s1_d = bus.pix_in;
        pix_s2_d = pix_s1_q;
        h_edge   = hs_s2_q & ~hs_p_q;
        h_fall   = ~hs_s2_q & hs_p_q;
        v_edge   = vs_s2_q & ~vs_p_q;
        v_fall   = ~vs_s2_q & vs_p_q;

        hcnt_d = h_edge ? 11'd1 : ((&hcnt_q) ? hcnt_q : hcnt_q + 11'd1);
        hpos_d = h_fall ? 11'd0 : ((&hpos_q) ? hpos_q : hpos_q + 11'd1);
        lcnt_d = v_edge ? 10'd0 : ((h_edge && !(&lcnt_q)) ? lcnt_q + 10'd1 : lcnt_q);
        lpos_d = v_fall ? 10'd0 : ((h_edge && !(&lpos_q)) ? lpos_q + 10'd1 : lpos_q);
        hper_d = h_edge ? hcnt_q : hper_q;
        vper_d = v_edge ? lcnt_q : vper_q;

        // hpos_d/lpos_d describe the slot currently in pix_s2_q, so x/y/pix stay aligned.
        vis         = (hpos_d >= H_LO) && (hpos_d < H_HI) && (lpos_d >= V_LO) && (lpos_d < V_HI);
        x_d         = vis ? 10'(hpos_d - H_LO) : 10'd0;
        y_d         = vis ? (lpos_d - V_LO) : 10'd0;
        pix_out_d   = vis ? pix_s2_q : 3'd0;
        pix_valid_d = locked_q & vis;
        frame_start_d = v_edge;
    end

    // H decision first, then V decision on the updated state when both edges coincide.
    always_comb begin
        state_d    = state_q;
        href_d     = href_q;
        vref_d     = vref_q;
        hbad_d     = hbad_q;
        hfirst_d   = hfirst_q;
        locked_d   = locked_q;
        sync_err_d = 1'b0;
        h_total_d  = h_total_q;
        v_total_d  = v_total_q;
        h_mis      = (hper_d != href_q) || (&hper_d);

        if (h_edge) begin
            case (state_q)
                FIRST, VERIFY: begin
                    if (hfirst_q) begin
                        href_d   = hper_d;
                        hfirst_d = 1'b0;
                    end else if (h_mis) begin
                        hbad_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if (h_mis) begin
                        sync_err_d = 1'b1;
                        locked_d   = 1'b0;
                        href_d     = hper_d;
                        vref_d     = vper_d;
                        h_total_d  = hper_d;
                        v_total_d  = vper_d;
                        // The frame holding the bad line can never be a clean verify frame.
                        hbad_d     = 1'b1;
                        state_d    = VERIFY;
                    end
                end
                default: ;
            endcase
        end

        if (v_edge) begin
            case (state_d)
                SEARCH: begin
                    hbad_d   = 1'b0;
                    hfirst_d = 1'b1;
                    state_d  = FIRST;
                end
                FIRST: begin
                    vref_d    = vper_d;
                    h_total_d = href_d;
                    v_total_d = vper_d;
                    hbad_d    = 1'b0;
                    state_d   = VERIFY;
                end
                VERIFY: begin
                    if (!hbad_d && (vper_d == vref_d) && !(&vper_d)) begin
                        locked_d = 1'b1;
                        state_d  = LOCKED;
                    end else begin
                        href_d    = hper_d;
                        vref_d    = vper_d;
                        h_total_d = hper_d;
                        v_total_d = vper_d;
                        hbad_d    = 1'b0;
                    end
                end
                LOCKED: begin
                    if ((vper_d != vref_q) || (&vper_d)) begin
                        sync_err_d = 1'b1;
                        locked_d   = 1'b0;
                        href_d     = hper_d;
                        vref_d     = vper_d;
                        h_total_d  = hper_d;
                        v_total_d  = vper_d;
                        hbad_d     = 1'b0;
                        state_d    = VERIFY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            hs_s1_q <= 1'b0; hs_s2_q <= 1'b0; hs_p_q <= 1'b0;
            vs_s1_q <= 1'b0; vs_s2_q <= 1'b0; vs_p_q <= 1'b0;
            pix_s1_q <= '0; pix_s2_q <= '0;
            hcnt_q <= '0; hpos_q <= '0; hper_q <= '0; href_q <= '0;
            lcnt_q <= '0; lpos_q <= '0; vper_q <= '0; vref_q <= '0;
            state_q <= SEARCH; hbad_q <= 1'b0; hfirst_q <= 1'b0;
            locked_q <= 1'b0; sync_err_q <= 1'b0; frame_start_q <= 1'b0;
            h_total_q <= '0; v_total_q <= '0;
            x_q <= '0; y_q <= '0; pix_out_q <= '0; pix_valid_q <= 1'b0;
        end else begin
            hs_s1_q <= hs_s1_d; hs_s2_q <= hs_s2_d; hs_p_q <= hs_p_d;
            vs_s1_q <= vs_s1_d; vs_s2_q <= vs_s2_d; vs_p_q <= vs_p_d;
            pix_s1_q <= pix_s1_d; pix_s2_q <= pix_s2_d;
            hcnt_q <= hcnt_d; hpos_q <= hpos_d; hper_q <= hper_d; href_q <= href_d;
            lcnt_q <= lcnt_d; lpos_q <= lpos_d; vper_q <= vper_d; vref_q <= vref_d;
            state_q <= state_d; hbad_q <= hbad_d; hfirst_q <= hfirst_d;
            locked_q <= locked_d; sync_err_q <= sync_err_d; frame_start_q <= frame_start_d;
            h_total_q <= h_total_d; v_total_q <= v_total_d;
            x_q <= x_d; y_q <= y_d; pix_out_q <= pix_out_d; pix_valid_q <= pix_valid_d;
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.pix_out     = pix_out_q;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.locked      = locked_q;
    assign bus.frame_start = frame_start_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.h_total     = h_total_q;
    assign bus.v_total     = v_total_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench: a scaled 40x20 VGA-style stream drives an active-low and an active-high decoder.
module tb_vga_sync_decoder;
    localparam int HB = 6, HA = 24, VB = 3, VA = 12;
    localparam int HT = 40, HS = 4, NL = 20, VS_C = 20;

    logic clk50 = 1'b0;
    logic rst;
    always #5 clk50 = ~clk50;

    vga_sync_if bus_a();
    vga_sync_if bus_b();

    vga_sync_decoder #(.SYNC_ACTIVE_LOW(1'b1), .H_BP(HB), .H_ACT(HA), .V_BP(VB), .V_ACT(VA))
        dut_a (.clk50(clk50), .rst(rst), .bus(bus_a.slave));
    vga_sync_decoder #(.SYNC_ACTIVE_LOW(1'b0), .H_BP(HB), .H_ACT(HA), .V_BP(VB), .V_ACT(VA))
        dut_b (.clk50(clk50), .rst(rst), .bus(bus_b.slave));

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int fs_cnt = 0, fs_cnt_b = 0, lock_fs = 0, lock_fs_b = 0;
    int err_cnt = 0, err_cyc = 0, valid_cnt = 0, hit_cnt = 0;
    logic [9:0] hit_x = '0, hit_y = '0;
    logic [2:0] hit_pix = '0;
    logic hit_valid = 1'b0, lk_prev = 1'b0, lk_prev_b = 1'b0;
    int pix_line = -1, pix_col = -1, mark_line = -1, mark_col = -1, mark_cyc = 0;
    int fs0 = 0, fs0_b = 0;

    always @(posedge clk50) cyc <= cyc + 1;

    // Event recorder; expectations are applied in the test tasks.
    always @(negedge clk50) begin
        lk_prev   <= bus_a.locked;
        lk_prev_b <= bus_b.locked;
        fs_cnt    <= fs_cnt + (bus_a.frame_start ? 1 : 0);
        fs_cnt_b  <= fs_cnt_b + (bus_b.frame_start ? 1 : 0);
        if (bus_a.locked && !lk_prev) lock_fs <= fs_cnt + (bus_a.frame_start ? 1 : 0);
        if (bus_b.locked && !lk_prev_b) lock_fs_b <= fs_cnt_b + (bus_b.frame_start ? 1 : 0);
        if (bus_a.sync_err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (bus_a.pix_valid) valid_cnt <= valid_cnt + 1;
        if (bus_a.pix_out != 3'd0) begin
            hit_cnt   <= hit_cnt + 1;
            hit_x     <= bus_a.x;
            hit_y     <= bus_a.y;
            hit_pix   <= bus_a.pix_out;
            hit_valid <= bus_a.pix_valid;
        end
    end

    task automatic drive(input logic hs, input logic vs, input logic [2:0] px);
        @(negedge clk50);
        bus_a.hsync_in = ~hs;
        bus_a.vsync_in = ~vs;
        bus_b.hsync_in = hs;
        bus_b.vsync_in = vs;
        bus_a.pix_in   = px;
        bus_b.pix_in   = px;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0);
    endtask

    // Line l starts with hsync asserted; vsync asserts at column VS_C of line 0 for two lines.
    task automatic run_frame(input int nlines, input int long_line);
        for (int l = 0; l < nlines; l++) begin
            int len;
            len = (l == long_line) ? HT + 1 : HT;
            for (int c = 0; c < len; c++) begin
                logic vs;
                vs = (l == 0 && c >= VS_C) || (l == 1) || (l == 2 && c < VS_C);
                drive(c < HS, vs, (l == pix_line && c == pix_col) ? 3'b101 : 3'b000);
                if (l == mark_line && c == mark_col) mark_cyc = cyc;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk50);
        n_chk++;
        if ({bus_a.x, bus_a.y, bus_a.pix_out, bus_a.pix_valid, bus_a.locked, bus_a.frame_start,
             bus_a.sync_err, bus_a.h_total, bus_a.v_total} !== '0) begin
            n_fail++; $display("FAIL reset_outs_a: got nonzero outputs, want all 0");
        end
        n_chk++;
        if ({bus_b.x, bus_b.y, bus_b.pix_out, bus_b.pix_valid, bus_b.locked, bus_b.frame_start,
             bus_b.sync_err, bus_b.h_total, bus_b.v_total} !== '0) begin
            n_fail++; $display("FAIL reset_outs_b: got nonzero outputs, want all 0");
        end
        rst = 1'b0;
        idle(10);
    endtask

    task automatic test_lock();
        fs0 = fs_cnt; fs0_b = fs_cnt_b;
        repeat (3) run_frame(NL, -1);
        n_chk++; if (bus_a.locked !== 1'b1) begin n_fail++; $display("FAIL lock_flag: got %b want 1", bus_a.locked); end
        n_chk++; if (lock_fs - fs0 != 3) begin n_fail++; $display("FAIL lock_edge: got %0d want 3", lock_fs - fs0); end
        n_chk++; if (fs_cnt - fs0 != 3) begin n_fail++; $display("FAIL frame_start_cnt: got %0d want 3", fs_cnt - fs0); end
        n_chk++; if (bus_a.h_total !== 11'd40) begin n_fail++; $display("FAIL h_total: got %0d want 40", bus_a.h_total); end
        n_chk++; if (bus_a.v_total !== 10'd20) begin n_fail++; $display("FAIL v_total: got %0d want 20", bus_a.v_total); end
    endtask

    task automatic test_polarity();
        n_chk++; if (bus_b.locked !== 1'b1) begin n_fail++; $display("FAIL pol_lock_flag: got %b want 1", bus_b.locked); end
        n_chk++; if (lock_fs_b - fs0_b != 3) begin n_fail++; $display("FAIL pol_lock_edge: got %0d want 3", lock_fs_b - fs0_b); end
        n_chk++; if (bus_b.h_total !== 11'd40) begin n_fail++; $display("FAIL pol_h_total: got %0d want 40", bus_b.h_total); end
        n_chk++; if (bus_b.v_total !== 10'd20) begin n_fail++; $display("FAIL pol_v_total: got %0d want 20", bus_b.v_total); end
    endtask

    task automatic test_pixel();
        int v0, h0;
        v0 = valid_cnt; h0 = hit_cnt;
        pix_line = 10; pix_col = HS + HB + 10;
        run_frame(NL, -1);
        pix_line = -1; pix_col = -1;
        n_chk++; if (hit_cnt - h0 != 1) begin n_fail++; $display("FAIL pix_hits: got %0d want 1", hit_cnt - h0); end
        n_chk++; if (hit_x !== 10'd10) begin n_fail++; $display("FAIL pix_x: got %0d want 10", hit_x); end
        n_chk++; if (hit_y !== 10'd5) begin n_fail++; $display("FAIL pix_y: got %0d want 5", hit_y); end
        n_chk++; if (hit_pix !== 3'd5) begin n_fail++; $display("FAIL pix_val: got %0d want 5", hit_pix); end
        n_chk++; if (hit_valid !== 1'b1) begin n_fail++; $display("FAIL pix_valid_at_hit: got %b want 1", hit_valid); end
        n_chk++; if (valid_cnt - v0 != HA * VA) begin n_fail++; $display("FAIL pix_valid_cnt: got %0d want %0d", valid_cnt - v0, HA * VA); end
    endtask

    task automatic test_stretch();
        int e0;
        e0 = err_cnt;
        mark_line = 8; mark_col = 0;
        run_frame(NL, 7);
        mark_line = -1;
        n_chk++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL str_err_cnt: got %0d want 1", err_cnt - e0); end
        n_chk++; if (err_cyc != mark_cyc + 3) begin n_fail++; $display("FAIL str_err_cyc: got %0d want %0d", err_cyc, mark_cyc + 3); end
        n_chk++; if (bus_a.locked !== 1'b0) begin n_fail++; $display("FAIL str_unlock: got %b want 0", bus_a.locked); end
        run_frame(NL, -1);
        n_chk++; if (bus_a.locked !== 1'b0) begin n_fail++; $display("FAIL str_still_verify: got %b want 0", bus_a.locked); end
        run_frame(NL, -1);
        n_chk++; if (bus_a.locked !== 1'b1) begin n_fail++; $display("FAIL str_relock: got %b want 1", bus_a.locked); end
    endtask

    task automatic test_short_frame();
        int e0;
        e0 = err_cnt;
        run_frame(NL - 1, -1);
        mark_line = 0; mark_col = VS_C;
        run_frame(NL, -1);
        mark_line = -1;
        n_chk++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL shf_err_cnt: got %0d want 1", err_cnt - e0); end
        n_chk++; if (err_cyc != mark_cyc + 3) begin n_fail++; $display("FAIL shf_err_cyc: got %0d want %0d", err_cyc, mark_cyc + 3); end
        n_chk++; if (bus_a.locked !== 1'b0) begin n_fail++; $display("FAIL shf_unlock: got %b want 0", bus_a.locked); end
        n_chk++; if (bus_a.v_total !== 10'd19) begin n_fail++; $display("FAIL shf_v_total: got %0d want 19", bus_a.v_total); end
        run_frame(NL, -1);
        n_chk++; if (bus_a.v_total !== 10'd20) begin n_fail++; $display("FAIL shf_v_total_back: got %0d want 20", bus_a.v_total); end
        n_chk++; if (bus_a.locked !== 1'b0) begin n_fail++; $display("FAIL shf_still_verify: got %b want 0", bus_a.locked); end
        run_frame(NL, -1);
        n_chk++; if (bus_a.locked !== 1'b1) begin n_fail++; $display("FAIL shf_relock: got %b want 1", bus_a.locked); end
    endtask

    task automatic test_mid_reset();
        run_frame(10, -1);
        n_chk++; if (bus_a.locked !== 1'b1) begin n_fail++; $display("FAIL mrst_pre_lock: got %b want 1", bus_a.locked); end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({bus_a.x, bus_a.y, bus_a.pix_out, bus_a.pix_valid, bus_a.locked, bus_a.frame_start,
             bus_a.sync_err, bus_a.h_total, bus_a.v_total} !== '0) begin
            n_fail++; $display("FAIL mrst_async_outs: got nonzero outputs, want all 0");
        end
        idle(4);
        rst = 1'b0;
        idle(5);
        fs0 = fs_cnt;
        run_frame(NL, -1);
        run_frame(NL, -1);
        n_chk++; if (bus_a.locked !== 1'b0) begin n_fail++; $display("FAIL mrst_early_lock: got %b want 0", bus_a.locked); end
        run_frame(NL, -1);
        n_chk++; if (bus_a.locked !== 1'b1) begin n_fail++; $display("FAIL mrst_relock: got %b want 1", bus_a.locked); end
        n_chk++; if (lock_fs - fs0 != 3) begin n_fail++; $display("FAIL mrst_lock_edge: got %0d want 3", lock_fs - fs0); end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.hsync_in = 1'b1; bus_a.vsync_in = 1'b1; bus_a.pix_in = 3'd0;
        bus_b.hsync_in = 1'b0; bus_b.vsync_in = 1'b0; bus_b.pix_in = 3'd0;
        test_reset();
        test_lock();
        test_polarity();
        test_pixel();
        test_stretch();
        test_short_frame();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
